// File: rtl/lsu_mem_if.sv
// lsu_mem_if: RV32I load/store unit between the execute stage and a
// word-wide data RAM with a combinational read port and a 32-bit write port.
// Sub-word stores are done as read-modify-write. Each request produces one
// response strobe carrying extended load data and error status.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_valid_i/ready_o    request handshake from/to the core
//   req_we_i               1 = store, 0 = load
//   req_funct3_i           RV32I funct3 width/sign selector
//   req_addr_i             byte address
//   req_wdata_i            right-aligned store data
//   rsp_valid_o            one-cycle response strobe
//   rsp_rdata_o            extended load data (0 for stores and errors)
//   rsp_err_o              01 misaligned/illegal funct3, 10 access fault
//   ram_rd_en_o/addr_o     RAM read request, word aligned
//   ram_rd_data_i          RAM read data, same cycle as ram_rd_en_o
//   ram_wr_en_o/addr_o     RAM write request, word aligned
//   ram_wr_data_o          RAM write word
module lsu_mem_if #(
    parameter logic [31:0] RAM_ORI = 32'h0020_0000,
    parameter logic [31:0] RAM_LEN = 32'h0010_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic [1:0]  rsp_err_o,
    output logic        ram_rd_en_o,
    output logic [31:0] ram_rd_addr_o,
    input  logic [31:0] ram_rd_data_i,
    output logic        ram_wr_en_o,
    output logic [31:0] ram_wr_addr_o,
    output logic [31:0] ram_wr_data_o
);

    typedef enum logic [2:0] {IDLE, LD, RMW_RD, WR, RESP} state_e;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] merge_q, merge_d;
    logic [1:0]  err_q, err_d;

    logic        ready, rsp_valid, rd_en, wr_en;
    logic [1:0]  acc_err;

    // Misaligned (including illegal funct3) takes priority over fault.
    // Range checks are done in 33 bits so RAM_ORI+RAM_LEN cannot wrap.
    function automatic logic [1:0] check_err(input logic we, input logic [2:0] f3,
                                             input logic [31:0] addr);
        logic bad_f3, mis, flt;
        bad_f3 = we ? (f3 > 3'b010)
                    : (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
        mis = bad_f3 || (f3[1:0] == 2'b01 && addr[0])
                     || (f3[1:0] == 2'b10 && addr[1:0] != 2'b00);
        flt = ({1'b0, addr} < {1'b0, RAM_ORI})
           || ({1'b0, addr} >= ({1'b0, RAM_ORI} + {1'b0, RAM_LEN}));
        if (mis)      return 2'b01;
        else if (flt) return 2'b10;
        else          return 2'b00;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lo,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        case (lo)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lo[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] merge_store(input logic [2:0] f3, input logic [1:0] lo,
                                                input logic [31:0] word,
                                                input logic [31:0] wd);
        logic [31:0] m;
        m = word;
        if (f3[1:0] == 2'b00) begin
            case (lo)
                2'd0:    m[7:0]   = wd[7:0];
                2'd1:    m[15:8]  = wd[7:0];
                2'd2:    m[23:16] = wd[7:0];
                default: m[31:24] = wd[7:0];
            endcase
        end else if (lo[1]) begin
            m[31:16] = wd[15:0];
        end else begin
            m[15:0] = wd[15:0];
        end
        return m;
    endfunction

    assign acc_err = check_err(req_we_i, req_funct3_i, req_addr_i);

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        funct3_d  = funct3_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        merge_d   = merge_q;
        err_d     = err_q;
        ready     = 1'b0;
        rsp_valid = 1'b0;
        rd_en     = 1'b0;
        wr_en     = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (req_valid_i) begin
                    we_d     = req_we_i;
                    funct3_d = req_funct3_i;
                    addr_d   = req_addr_i;
                    wdata_d  = req_wdata_i;
                    rdata_d  = 32'd0;
                    merge_d  = 32'd0;
                    err_d    = acc_err;
                    if (acc_err != 2'b00)           state_d = RESP;
                    else if (!req_we_i)             state_d = LD;
                    else if (req_funct3_i == 3'b010) state_d = WR;
                    else                            state_d = RMW_RD;
                end
            end
            LD: begin
                rd_en   = 1'b1;
                rdata_d = load_extend(funct3_q, addr_q[1:0], ram_rd_data_i);
                state_d = RESP;
            end
            RMW_RD: begin
                rd_en   = 1'b1;
                merge_d = merge_store(funct3_q, addr_q[1:0], ram_rd_data_i, wdata_q);
                state_d = WR;
            end
            WR: begin
                wr_en   = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            merge_q  <= 32'd0;
            err_q    <= 2'b00;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            merge_q  <= merge_d;
            err_q    <= err_d;
        end
    end

    // Outputs are gated with rst_ni so everything (ready included) is
    // forced low combinationally while reset is held; this also stops a
    // pending write from committing on the next edge.
    assign req_ready_o   = rst_ni & ready;
    assign rsp_valid_o   = rst_ni & rsp_valid;
    assign rsp_rdata_o   = rsp_valid_o ? rdata_q : 32'd0;
    assign rsp_err_o     = rsp_valid_o ? err_q : 2'b00;
    assign ram_rd_en_o   = rst_ni & rd_en;
    assign ram_rd_addr_o = ram_rd_en_o ? {addr_q[31:2], 2'b00} : 32'd0;
    assign ram_wr_en_o   = rst_ni & wr_en;
    assign ram_wr_addr_o = ram_wr_en_o ? {addr_q[31:2], 2'b00} : 32'd0;
    assign ram_wr_data_o = !ram_wr_en_o ? 32'd0
                         : (funct3_q[1:0] == 2'b10) ? wdata_q : merge_q;

endmodule

// File: tb/tb_lsu_mem_if.sv
module tb_lsu_mem_if;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [2:0]  req_funct3_i = 3'd0;
    logic [31:0] req_addr_i = 32'd0;
    logic [31:0] req_wdata_i = 32'd0;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic [1:0]  rsp_err_o;
    logic        ram_rd_en_o;
    logic [31:0] ram_rd_addr_o;
    logic [31:0] ram_rd_data_i;
    logic        ram_wr_en_o;
    logic [31:0] ram_wr_addr_o;
    logic [31:0] ram_wr_data_o;

    int checks = 0;
    int passes = 0;

    lsu_mem_if dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_we_i(req_we_i), .req_funct3_i(req_funct3_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .ram_rd_en_o(ram_rd_en_o), .ram_rd_addr_o(ram_rd_addr_o),
        .ram_rd_data_i(ram_rd_data_i),
        .ram_wr_en_o(ram_wr_en_o), .ram_wr_addr_o(ram_wr_addr_o),
        .ram_wr_data_o(ram_wr_data_o)
    );

    always #5 clk_i = ~clk_i;

    // Small RAM model: 256 words, indexed by word address bits [9:2].
    logic [31:0] mem [0:255];
    logic        pre_en = 1'b0;
    logic [7:0]  pre_idx = 8'd0;
    logic [31:0] pre_data = 32'd0;

    assign ram_rd_data_i = mem[ram_rd_addr_o[9:2]];

    always @(posedge clk_i) begin
        if (ram_wr_en_o)  mem[ram_wr_addr_o[9:2]] <= ram_wr_data_o;
        else if (pre_en)  mem[pre_idx] <= pre_data;
    end

    // Continuous protocol observation.
    int viol = 0;
    int viol_rst = 0;
    int rsp_cnt = 0;
    always @(negedge clk_i) begin
        if (rsp_valid_o) rsp_cnt <= rsp_cnt + 1;
        if (!rst_ni) begin
            if (req_ready_o || rsp_valid_o || ram_rd_en_o || ram_wr_en_o ||
                rsp_rdata_o != 0 || rsp_err_o != 0 || ram_rd_addr_o != 0 ||
                ram_wr_addr_o != 0 || ram_wr_data_o != 0)
                viol_rst <= viol_rst + 1;
        end else if ((ram_rd_en_o && ram_wr_en_o) ||
                     (!ram_rd_en_o && ram_rd_addr_o != 0) ||
                     (!ram_wr_en_o && (ram_wr_addr_o != 0 || ram_wr_data_o != 0))) begin
            viol <= viol + 1;
        end
    end

    int          rd_cnt, wr_cnt;
    logic [31:0] last_rd_addr, last_wr_addr, last_wr_data;

    task automatic preload(input logic [7:0] idx, input logic [31:0] d);
        pre_idx = idx; pre_data = d; pre_en = 1'b1;
        @(posedge clk_i);
        #1 pre_en = 1'b0;
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output int lat,
                          output logic [31:0] rd, output logic [1:0] er);
        int w;
        w = 0;
        @(negedge clk_i);
        while (!req_ready_o && w < 10) begin
            @(negedge clk_i);
            w++;
        end
        checks++;
        if (req_ready_o !== 1'b1) $display("FAIL ready_wait: ready=%b want 1", req_ready_o);
        else passes++;
        req_we_i = we; req_funct3_i = f3; req_addr_i = addr; req_wdata_i = wd;
        req_valid_i = 1'b1;
        @(posedge clk_i);
        #1 req_valid_i = 1'b0;
        rd_cnt = 0; wr_cnt = 0; lat = 0; rd = 32'd0; er = 2'b00;
        last_rd_addr = 32'd0; last_wr_addr = 32'd0; last_wr_data = 32'd0;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(negedge clk_i);
            if (ram_rd_en_o) begin rd_cnt++; last_rd_addr = ram_rd_addr_o; end
            if (ram_wr_en_o) begin
                wr_cnt++; last_wr_addr = ram_wr_addr_o; last_wr_data = ram_wr_data_o;
            end
            if (rsp_valid_o) begin lat = k; rd = rsp_rdata_o; er = rsp_err_o; end
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        req_valid_i = 1'b1;
        req_addr_i = 32'h0020_0100;
        repeat (3) @(negedge clk_i);
        checks++;
        if ({req_ready_o, rsp_valid_o, ram_rd_en_o, ram_wr_en_o} !== 4'b0000)
            $display("FAIL reset_outputs: ready/rsp/rd/wr=%b want 0000",
                     {req_ready_o, rsp_valid_o, ram_rd_en_o, ram_wr_en_o});
        else passes++;
        checks++;
        if (rsp_rdata_o !== 32'd0 || rsp_err_o !== 2'b00)
            $display("FAIL reset_rsp: rdata=%h err=%b want 0", rsp_rdata_o, rsp_err_o);
        else passes++;
        req_valid_i = 1'b0;
        rst_ni = 1'b1;
        #1;
        checks++;
        if (req_ready_o !== 1'b1) $display("FAIL reset_release_ready: %b want 1", req_ready_o);
        else passes++;
    endtask

    task automatic test_load();
        logic [2:0]  f3 [8]  = '{3'b000, 3'b100, 3'b000, 3'b100, 3'b001, 3'b101, 3'b001, 3'b010};
        logic [31:0] ad [8]  = '{32'h0020_0103, 32'h0020_0103, 32'h0020_0100, 32'h0020_0101,
                                 32'h0020_0100, 32'h0020_0102, 32'h0020_0102, 32'h0020_0100};
        logic [31:0] ex [8]  = '{32'hFFFF_FF88, 32'h0000_0088, 32'hFFFF_FFBB, 32'h0000_00AA,
                                 32'hFFFF_AABB, 32'h0000_8899, 32'hFFFF_8899, 32'h8899_AABB};
        int lat; logic [31:0] rd; logic [1:0] er;
        preload(8'h40, 32'h8899_AABB);
        for (int i = 0; i < 8; i++) begin
            do_req(1'b0, f3[i], ad[i], 32'd0, lat, rd, er);
            checks++;
            if (rd !== ex[i]) $display("FAIL load_data[%0d]: got %h want %h", i, rd, ex[i]);
            else passes++;
            checks++;
            if (lat != 2 || er !== 2'b00)
                $display("FAIL load_lat_err[%0d]: lat=%0d err=%b want 2/00", i, lat, er);
            else passes++;
            checks++;
            if (rd_cnt != 1 || wr_cnt != 0 || last_rd_addr !== 32'h0020_0100)
                $display("FAIL load_ram[%0d]: rd=%0d wr=%0d addr=%h want 1/0/00200100",
                         i, rd_cnt, wr_cnt, last_rd_addr);
            else passes++;
        end
    endtask

    task automatic test_store_sub();
        logic [2:0]  f3 [2] = '{3'b000, 3'b001};
        logic [31:0] ad [2] = '{32'h0020_0101, 32'h0020_0102};
        logic [31:0] wd [2] = '{32'h1234_5677, 32'h0000_CAFE};
        logic [31:0] ex [2] = '{32'h8899_77BB, 32'hCAFE_AABB};
        logic [2:0]  lf [3] = '{3'b001, 3'b101, 3'b010};
        logic [31:0] la [3] = '{32'h0020_0102, 32'h0020_0102, 32'h0020_0100};
        logic [31:0] le [3] = '{32'hFFFF_CAFE, 32'h0000_CAFE, 32'hCAFE_AABB};
        int lat; logic [31:0] rd; logic [1:0] er;
        for (int i = 0; i < 2; i++) begin
            preload(8'h40, 32'h8899_AABB);
            do_req(1'b1, f3[i], ad[i], wd[i], lat, rd, er);
            checks++;
            if (lat != 3 || er !== 2'b00 || rd !== 32'd0)
                $display("FAIL store_rsp[%0d]: lat=%0d err=%b rdata=%h want 3/00/0", i, lat, er, rd);
            else passes++;
            checks++;
            if (rd_cnt != 1 || wr_cnt != 1 || last_wr_addr !== 32'h0020_0100)
                $display("FAIL store_ram[%0d]: rd=%0d wr=%0d waddr=%h want 1/1/00200100",
                         i, rd_cnt, wr_cnt, last_wr_addr);
            else passes++;
            checks++;
            if (last_wr_data !== ex[i] || mem[8'h40] !== ex[i])
                $display("FAIL store_word[%0d]: wdata=%h mem=%h want %h",
                         i, last_wr_data, mem[8'h40], ex[i]);
            else passes++;
        end
        for (int i = 0; i < 3; i++) begin
            do_req(1'b0, lf[i], la[i], 32'd0, lat, rd, er);
            checks++;
            if (rd !== le[i] || er !== 2'b00)
                $display("FAIL store_readback[%0d]: got %h err=%b want %h/00", i, rd, er, le[i]);
            else passes++;
        end
    endtask

    task automatic test_errors();
        logic        we [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [2:0]  f3 [8] = '{3'b010, 3'b010, 3'b001, 3'b011, 3'b100, 3'b010, 3'b010, 3'b101};
        logic [31:0] ad [8] = '{32'h0020_0102, 32'h0000_1000, 32'h0000_1001, 32'h0020_0100,
                                32'h0020_0100, 32'h0030_0000, 32'h001F_FFFC, 32'h0020_0101};
        logic [1:0]  ex [8] = '{2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b01};
        int lat; logic [31:0] rd; logic [1:0] er;
        for (int i = 0; i < 8; i++) begin
            do_req(we[i], f3[i], ad[i], 32'hFFFF_FFFF, lat, rd, er);
            checks++;
            if (er !== ex[i] || rd !== 32'd0)
                $display("FAIL err_code[%0d]: err=%b rdata=%h want %b/0", i, er, rd, ex[i]);
            else passes++;
            checks++;
            if (lat != 1 || rd_cnt != 0 || wr_cnt != 0)
                $display("FAIL err_noram[%0d]: lat=%0d rd=%0d wr=%0d want 1/0/0",
                         i, lat, rd_cnt, wr_cnt);
            else passes++;
        end
        // Last word inside the RAM window is legal.
        do_req(1'b0, 3'b010, 32'h002F_FFFC, 32'd0, lat, rd, er);
        checks++;
        if (er !== 2'b00 || lat != 2 || last_rd_addr !== 32'h002F_FFFC)
            $display("FAIL err_top_ok: err=%b lat=%0d addr=%h want 00/2/002ffffc",
                     er, lat, last_rd_addr);
        else passes++;
    endtask

    task automatic test_reset_mid();
        int base;
        int lat; logic [31:0] rd; logic [1:0] er;
        preload(8'h40, 32'h8899_AABB);
        @(negedge clk_i);
        req_we_i = 1'b1; req_funct3_i = 3'b000; req_addr_i = 32'h0020_0100;
        req_wdata_i = 32'h0000_0055; req_valid_i = 1'b1;
        @(posedge clk_i);
        #1 req_valid_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (ram_rd_en_o !== 1'b1) $display("FAIL rstmid_rmw: rd_en=%b want 1", ram_rd_en_o);
        else passes++;
        @(negedge clk_i);
        checks++;
        if (ram_wr_en_o !== 1'b1) $display("FAIL rstmid_wr: wr_en=%b want 1", ram_wr_en_o);
        else passes++;
        base = rsp_cnt;
        rst_ni = 1'b0;
        #1;
        checks++;
        if (ram_wr_en_o !== 1'b0 || req_ready_o !== 1'b0)
            $display("FAIL rstmid_drop: wr_en=%b ready=%b want 0/0", ram_wr_en_o, req_ready_o);
        else passes++;
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        checks++;
        if (req_ready_o !== 1'b1) $display("FAIL rstmid_ready: %b want 1", req_ready_o);
        else passes++;
        @(negedge clk_i);
        checks++;
        if (rsp_cnt != base || mem[8'h40] !== 32'h8899_AABB)
            $display("FAIL rstmid_abort: rsp=%0d mem=%h want %0d/8899aabb",
                     rsp_cnt - base, mem[8'h40], 0);
        else passes++;
        do_req(1'b0, 3'b010, 32'h0020_0100, 32'd0, lat, rd, er);
        checks++;
        if (rd !== 32'h8899_AABB || er !== 2'b00)
            $display("FAIL rstmid_lw: got %h err=%b want 8899aabb/00", rd, er);
        else passes++;
    endtask

    task automatic test_back_to_back();
        // Expected {ready, rsp_valid, rd_en, wr_en} in the cycles after the first accept.
        logic [3:0] ex [6] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0100, 4'b1000};
        logic [3:0] ob;
        preload(8'h40, 32'h8899_AABB);
        preload(8'h41, 32'h0000_0000);
        @(negedge clk_i);
        checks++;
        if (req_ready_o !== 1'b1) $display("FAIL b2b_start_ready: %b want 1", req_ready_o);
        else passes++;
        req_we_i = 1'b0; req_funct3_i = 3'b010; req_addr_i = 32'h0020_0100;
        req_wdata_i = 32'd0; req_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        req_we_i = 1'b1; req_addr_i = 32'h0020_0104; req_wdata_i = 32'hDEAD_BEEF;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk_i);
            ob = {req_ready_o, rsp_valid_o, ram_rd_en_o, ram_wr_en_o};
            checks++;
            if (ob !== ex[k-1]) $display("FAIL b2b_cycle[%0d]: rdy/rsp/rd/wr=%b want %b",
                                         k, ob, ex[k-1]);
            else passes++;
            if (k == 2) begin
                checks++;
                if (rsp_rdata_o !== 32'h8899_AABB)
                    $display("FAIL b2b_lw_data: %h want 8899aabb", rsp_rdata_o);
                else passes++;
            end
            if (k == 4) begin
                checks++;
                if (ram_wr_addr_o !== 32'h0020_0104 || ram_wr_data_o !== 32'hDEAD_BEEF)
                    $display("FAIL b2b_sw_port: addr=%h data=%h want 00200104/deadbeef",
                             ram_wr_addr_o, ram_wr_data_o);
                else passes++;
            end
            @(posedge clk_i);
            #1;
            if (k == 3) req_valid_i = 1'b0;
        end
        checks++;
        if (mem[8'h41] !== 32'hDEAD_BEEF)
            $display("FAIL b2b_sw_mem: %h want deadbeef", mem[8'h41]);
        else passes++;
    endtask

    task automatic test_invariants();
        checks++;
        if (viol != 0) $display("FAIL ram_port_rules: %0d bad cycles want 0", viol);
        else passes++;
        checks++;
        if (viol_rst != 0) $display("FAIL reset_quiet: %0d bad cycles want 0", viol_rst);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_load();
        test_store_sub();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        test_invariants();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation limit reached, %0d/%0d checks passed", passes, checks);
        $fatal(1);
    end

endmodule

// File: doc/lsu_mem_if.md
Name: lsu_mem_if

Overview:
- Load/store unit sitting between the execute stage and the data-RAM port of the core memory model.
- Accepts one load or store per transaction and translates RV32I sub-word accesses into word-aligned RAM accesses.
- The RAM port reads combinationally and writes 4 bytes per write, so SB/SH use read-modify-write.
- Returns extended load data plus misaligned/access-fault status to the core.

Parameters:
- RAM_ORI, 'h20_0000, base byte address of data RAM.
- RAM_LEN, 'h10_0000, RAM size in bytes; valid range is [RAM_ORI, RAM_ORI+RAM_LEN).

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset; asynchronous, active-low.
- req_valid_i  input  1  core request valid.
- req_ready_o  output  1  LSU can accept a request.
- req_we_i  input  1  1 = store, 0 = load.
- req_funct3_i  input  3  RV32I funct3 (LB/LH/LW/LBU/LHU; SB/SH/SW).
- req_addr_i  input  32  byte address.
- req_wdata_i  input  32  store data, right-aligned.
- rsp_valid_o  output  1  one-cycle response strobe.
- rsp_rdata_o  output  32  extended load data; 0 for stores and errors.
- rsp_err_o  output  2  01 misaligned, 10 access fault, 00 ok.
- ram_rd_en_o  output  1  RAM read enable.
- ram_rd_addr_o  output  32  RAM read address, word aligned.
- ram_rd_data_i  input  32  RAM read data; combinational, valid in the same cycle as rd_en.
- ram_wr_en_o  output  1  RAM write enable, sampled by RAM at posedge.
- ram_wr_addr_o  output  32  RAM write address, word aligned.
- ram_wr_data_o  output  32  RAM write word.

Behaviour:
- Reset (rst_ni low, async):
  - State goes to IDLE.
  - All outputs are 0, including req_ready_o, for the whole time rst_ni is low.
  - Captured request registers clear.
- Registered FSM states: IDLE, LD, RMW_RD, WR, RESP.
- IDLE:
  - req_ready_o = 1.
  - On posedge with req_valid_i = 1, latch we/funct3/addr/wdata and compute the error.
- Error check on accept (misaligned has priority over fault):
  - Misaligned: LH/LHU/SH with addr[0] = 1; LW/SW with addr[1:0] != 0.
  - Invalid funct3 (011, 110, 111 for loads; anything other than 000/001/010 for stores) also reports 01.
  - Fault: addr < RAM_ORI or addr >= RAM_ORI+RAM_LEN.
  - On any error, go directly to RESP; no RAM enable is ever asserted.
- Next state when there is no error:
  - Load goes to LD.
  - SW goes to WR.
  - SB/SH go to RMW_RD.
- Addressing: ram_rd_addr_o and ram_wr_addr_o = {addr[31:2], 2'b00}.
- LD:
  - ram_rd_en_o = 1.
  - At the edge, capture the lane selected by addr[1:0] into the response register.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Halfword lane uses addr[1]: 0 selects [15:0], 1 selects [31:16].
  - Next state RESP.
- RMW_RD:
  - ram_rd_en_o = 1.
  - Capture the merged word: read word with the byte/halfword lane replaced by wdata[7:0] or wdata[15:0].
  - Next state WR.
- WR:
  - ram_wr_en_o = 1 for exactly one cycle.
  - ram_wr_data_o = merged word (SB/SH) or wdata (SW).
  - Next state RESP.
- RESP:
  - rsp_valid_o = 1 for one cycle, with rsp_rdata_o and rsp_err_o held.
  - Next state IDLE.
  - req_ready_o = 0, so no request is accepted in RESP.
- Latency, counted from the accept edge to the rsp_valid cycle:
  - Error: 1 cycle.
  - Load: 2 cycles.
  - SW: 2 cycles.
  - SB/SH: 3 cycles.
- Back-to-back throughput: the next accept happens in the IDLE cycle after RESP.
- RAM outputs: addresses and data are 0 whenever the corresponding enable is 0. rd_en and wr_en are never asserted together.
- Reset mid-transaction:
  - Enables drop combinationally the moment rst_ni falls, so a pending WR does not commit.
  - No rsp_valid is issued for the aborted request.
- Inputs are ignored while req_ready_o = 0. The core holds its request until it is accepted.

Test Plan:
- Pre-load RAM word at 0x0020_0100 = 0x8899AABB. LB at 0x0020_0103 -> rd_en with addr 0x0020_0100; rsp_rdata 0xFFFFFF88 two cycles after accept, err 00. LBU at the same address -> 0x00000088.
- SB addr 0x0020_0101, wdata 0x12345677 -> RMW_RD then a single wr_en with addr 0x0020_0100, data 0x889977BB; rsp three cycles after accept.
- SH addr 0x0020_0102, wdata 0x0000CAFE -> write 0xCAFEAABB. A following LH at 0x0020_0102 -> 0xFFFFCAFE; LHU -> 0x0000CAFE; LW at 0x0020_0100 -> 0xCAFEAABB.
- Error cases, each with no RAM enable ever asserted:
  - LW at 0x0020_0102 -> err 01, rdata 0, rsp one cycle after accept.
  - SW at 0x0000_1000 -> err 10.
  - LH at 0x0000_1001 -> err 01 (priority over fault).
- Pull rst_ni low during WR of an SB to 0x0020_0100 -> wr_en falls immediately, word stays 0x8899AABB, no rsp_valid. After release, req_ready_o = 1 and a new LW returns 0x8899AABB.
- Hold req_valid_i high with LW then SW back-to-back -> req_ready_o low in LD/WR/RESP; second accept lands exactly in the cycle after the first rsp_valid.
